// File: rtl/alu_seq.sv
// alu_seq: clocked, parametrised ALU with two valid/ready handshakes.
//   Operands and opcode are taken over in_valid/in_ready. The result and flags
//   are returned over out_valid/out_ready.
//   Single-cycle ops: add, sub, and, or, xor, shl (logical), sra (arithmetic).
//   Build option ALU_MUL_EN: when defined, opcode 101 is an iterative shift-add
//   multiply. It takes N cycles in the MUL state and returns the low N bits of
//   the signed product.
//   When ALU_MUL_EN is undefined, opcode 101 is a single-cycle op that returns
//   0 with overflow set.
//   Flags and dOut change only on entry to DONE. They hold their last value otherwise.
module alu_seq #(
   parameter int N = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          control,
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] dOut,
   output logic                overflow,
   output logic                zero,
   output logic                negative,
   output logic                busy
);

   localparam int CNT_W = $clog2(N) + 1;
   localparam int SH_W  = CNT_W - 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_e;
`endif

   state_e              state_q, state_d;
   logic signed [N-1:0] sum, diff, alu_res, res_d;
   logic [SH_W-1:0]     shamt;
   logic                alu_ovf, ovf_d, load_res;

   assign sum   = a + b;
   assign diff  = a - b;
   assign shamt = b[SH_W-1:0];

   // Single-cycle result and overflow for the op presented at the input.
   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (control)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_MUL: alu_ovf = 1'b1;   // single-cycle form: result 0, overflow flagged
         OP_SHL: alu_res = a << shamt;
         OP_SRA: alu_res = a >>> shamt;
      endcase
   end

`ifdef ALU_MUL_EN
   logic [N-1:0]     abs_a, abs_b, mplier;
   logic [2*N-1:0]   mcand, acc, acc_nxt, prod;
   logic             sign, mul_ovf, mul_start;
   logic [CNT_W-1:0] cnt;

   // The most negative operand has magnitude 2^(N-1). That value is still
   // exact when read as N-bit unsigned.
   assign abs_a     = a[N-1] ? -a : a;
   assign abs_b     = b[N-1] ? -b : b;
   assign acc_nxt   = mplier[0] ? acc + mcand : acc;
   assign prod      = sign ? -acc_nxt : acc_nxt;
   assign mul_ovf   = prod[2*N-1:N] != {N{prod[N-1]}};
   assign mul_start = (state_q == S_IDLE) && in_valid && (control == OP_MUL);

   // Shift-add multiplier: load magnitudes on accept, then do one partial product per MUL cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         sign   <= 1'b0;
         cnt    <= '0;
      end else if (mul_start) begin
         mcand  <= {{N{1'b0}}, abs_a};
         mplier <= abs_b;
         acc    <= '0;
         sign   <= a[N-1] ^ b[N-1];
         cnt    <= CNT_W'(N);
      end else if (state_q == S_MUL) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 1'b1;
      end
   end
`endif

   // Next state, plus selection of the result to capture on entry to DONE.
   always_comb begin
      state_d  = state_q;
      load_res = 1'b0;
      res_d    = alu_res;
      ovf_d    = alu_ovf;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
`ifdef ALU_MUL_EN
               if (control == OP_MUL) begin
                  state_d = S_MUL;
               end else begin
                  state_d  = S_DONE;
                  load_res = 1'b1;
               end
`else
               state_d  = S_DONE;
               load_res = 1'b1;
`endif
            end
         end
`ifdef ALU_MUL_EN
         S_MUL: begin
            if (cnt == CNT_W'(1)) begin
               state_d  = S_DONE;
               load_res = 1'b1;
               res_d    = prod[N-1:0];
               ovf_d    = mul_ovf;
            end
         end
`endif
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Result and flag registers, updated only on the transition into DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dOut     <= '0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
      end else if (load_res) begin
         dOut     <= res_d;
         overflow <= ovf_d;
         zero     <= (res_d == '0);
         negative <= res_d[N-1];
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq with N=16.
//   The stimulus pushes the hand-computed result of each op when it is accepted.
//   A monitor pops that entry and compares it at each output handshake.
//   The same monitor also checks the out_valid latency.
//   Multiply cases run when ALU_MUL_EN is defined. Otherwise the single-cycle
//   opcode 101 is exercised.
module tb_alu_seq;

   localparam int MUL_LAT = 17;

   typedef struct {
      string       name;
      logic [15:0] d;
      logic        o, z, n;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  control;
   logic [15:0] a, b, dOut;
   logic        overflow, zero, negative, busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   lat_seen = 1'b0;
   exp_t sb[$];

   alu_seq #(.N(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .control(control), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .dOut(dOut), .overflow(overflow), .zero(zero), .negative(negative), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: check the latency on the first out_valid, then check data at the handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            if (!lat_seen) begin
               lat_seen = 1'b1;
               check({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
            end
            if (out_ready) begin
               exp_t e;
               e = sb.pop_front();
               lat_seen = 1'b0;
               check({e.name, "_dout"},     32'(dOut),     32'(e.d));
               check({e.name, "_overflow"}, 32'(overflow), 32'(e.o));
               check({e.name, "_zero"},     32'(zero),     32'(e.z));
               check({e.name, "_negative"}, 32'(negative), 32'(e.n));
            end
         end
      end
   end

   // Present one op, wait until it is accepted, and push its expected response.
   // The caller is at posedge+1. The task returns at posedge+1 just after the accept edge.
   task automatic issue(input string name, input logic [2:0] op, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] ed, input logic eo,
                        input logic ez, input logic en, input int lat, output int acc_c);
      exp_t e;
      bit   ok = 1'b0;
      acc_c    = -1;
      control  = op;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok    = 1'b1;
            acc_c = cyc + 1;
            e     = '{name, ed, eo, ez, en, lat, acc_c};
            sb.push_back(e);
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: in_ready never seen, expected accept within 100 cycles", name);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait, with a bound, until every pushed op has been returned and the DUT is idle.
   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !out_valid) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: %0d results outstanding, expected 0", name, sb.size());
      end
   endtask

   initial begin
      int acc_c, cp;
      rst_n = 1'b1; in_valid = 1'b0; control = '0; a = '0; b = '0; out_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_dout",      32'(dOut),      32'd0);
      check("rst_flags",     {29'd0, overflow, zero, negative}, 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("in_ready_after_reset", 32'(in_ready), 32'd1);

      // Single-cycle ops.
      issue("add_ovf",  3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 1, 1, acc_c);
      issue("sub_zero", 3'b001, 16'h0005, 16'h0005, 16'h0000, 0, 1, 0, 1, acc_c);
      issue("sub_ovf",  3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 0, 1, acc_c);
      issue("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 0, 1, acc_c);
      issue("and",      3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 1, acc_c);
      issue("or",       3'b011, 16'h8000, 16'h0001, 16'h8001, 0, 0, 1, 1, acc_c);
      issue("xor",      3'b100, 16'hAAAA, 16'h5555, 16'hFFFF, 0, 0, 1, 1, acc_c);
      issue("sra3",     3'b111, 16'h8000, 16'h0003, 16'hF000, 0, 0, 1, 1, acc_c);
      issue("shl_b11",  3'b110, 16'h0001, 16'h0011, 16'h0002, 0, 0, 0, 1, acc_c);
      issue("shl15",    3'b110, 16'h0001, 16'h000F, 16'h8000, 0, 0, 1, 1, acc_c);

`ifdef ALU_MUL_EN
      issue("mul_m3x7",   3'b101, 16'hFFFD, 16'h0007, 16'hFFEB, 0, 0, 1, MUL_LAT, acc_c);
      issue("mul_ovf",    3'b101, 16'h0100, 16'h0100, 16'h0000, 1, 1, 0, MUL_LAT, acc_c);
      issue("mul_minx1",  3'b101, 16'h8000, 16'h0001, 16'h8000, 0, 0, 1, MUL_LAT, acc_c);
      issue("mul_minxm1", 3'b101, 16'h8000, 16'hFFFF, 16'h8000, 1, 0, 1, MUL_LAT, acc_c);
      issue("mul_3x4",    3'b101, 16'h0003, 16'h0004, 16'h000C, 0, 0, 0, MUL_LAT, acc_c);
`else
      issue("op101_3x4",  3'b101, 16'h0003, 16'h0004, 16'h0000, 1, 1, 0, 1, acc_c);
`endif
      wait_idle("ops");

      // Backpressure: the result must hold while out_ready is low, and no new op may be taken.
      out_ready = 1'b0;
      issue("bp_xor", 3'b100, 16'h1234, 16'h00FF, 16'h12CB, 0, 0, 0, 1, acc_c);
      control = 3'b000; a = 16'h0002; b = 16'h0003; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_hold_dout",     32'(dOut),      32'h12CB);
         check("bp_hold_flags",    {29'd0, overflow, zero, negative}, 32'd0);
         check("bp_in_ready",      32'(in_ready),  32'd0);
         check("bp_out_valid",     32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1 cp = cyc;
      out_ready = 1'b1;
      issue("bp_add", 3'b000, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 1, acc_c);
      check("bp_accept_cycle", 32'(acc_c), 32'(cp + 2));
      wait_idle("bp");

      // Reset in the middle of an op. It is abandoned and no output appears.
      issue("pre_rst", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 1, 1, acc_c);
      wait_idle("pre_rst");
`ifdef ALU_MUL_EN
      issue("mul_abandon", 3'b101, 16'h0009, 16'h0005, 16'h002D, 0, 0, 0, MUL_LAT, acc_c);
      repeat (4) @(posedge clk);
`else
      out_ready = 1'b0;
      issue("done_abandon", 3'b100, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 1, 1, acc_c);
      repeat (2) @(posedge clk);
`endif
      #1 check("busy_before_rst", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      sb.delete();
      lat_seen = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_dout",      32'(dOut),      32'd0);
      check("midrst_flags",     {29'd0, overflow, zero, negative}, 32'd0);
      check("midrst_busy",      32'(busy),      32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_in_ready",  32'(in_ready),  32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      issue("post_rst_add", 3'b000, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 1, acc_c);
      wait_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
